// File: rtl/floatmul_pkg.sv
// Shared types for the float multiplier datapath: raw IEEE-754 binary32 words
// and the unpacked form with an explicit hidden bit.
package floatmul_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [23:0] mantissa;
    } float32_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } ieee754_t;

    // Inf/NaN fall through the normal path untouched (hidden bit 1); only a
    // zero exponent field gets special treatment.
    function automatic float32_t unpack_f32(ieee754_t w, bit flush);
        float32_t r;
        r.sign     = w.sign;
        r.exponent = w.exponent;
        if (w.exponent == 8'd0)
            r.mantissa = flush ? 24'd0 : {1'b0, w.fraction};
        else
            r.mantissa = {1'b1, w.fraction};
        return r;
    endfunction

endpackage

// File: rtl/float_unpack_fork.sv
// Multiplier operand front-end: accepts one binary32 pair per handshake, unpacks
// both words and presents them on two independently draining valid/ready streams.
module float_unpack_fork
    import floatmul_pkg::*;
#(
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        busy,
    input  logic        i_valid,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        i_ready,
    output logic        a_valid,
    output float32_t    a_payload,
    input  logic        a_ready,
    output logic        b_valid,
    output float32_t    b_payload,
    input  logic        b_ready,
    output logic [15:0] pair_count
);

    logic a_pend;
    logic b_pend;
    logic accept;

    // A new pair may enter in the same cycle the last pending half leaves.
    assign i_ready = ~rst & (~a_pend | a_ready) & (~b_pend | b_ready);
    assign accept  = i_valid & i_ready;
    assign a_valid = a_pend;
    assign b_valid = b_pend;
    assign busy    = a_pend | b_pend;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_pend    <= 1'b0;
            a_payload <= '0;
        end else if (accept) begin
            a_pend    <= 1'b1;
            a_payload <= unpack_f32(ieee754_t'(i_a), FLUSH_DENORM);
        end else if (a_pend && a_ready) begin
            a_pend    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_pend    <= 1'b0;
            b_payload <= '0;
        end else if (accept) begin
            b_pend    <= 1'b1;
            b_payload <= unpack_f32(ieee754_t'(i_b), FLUSH_DENORM);
        end else if (b_pend && b_ready) begin
            b_pend    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            pair_count <= '0;
        else if (accept)
            pair_count <= pair_count + 16'd1;
    end

endmodule
